// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: word width, fetch FSM states and the IF/ID bundle.
package arm_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] INSTR_NOP = 32'd0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instru;
        logic              valid;
    } ifid_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with redirect load, hold and sequential increment.
module pc_reg
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0,
    parameter logic [WORD_W-1:0] PC_STEP  = 32'd4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_addr_i,
    input  logic              hold_i,
    output logic [WORD_W-1:0] pc_o
);
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    // Load beats hold so a redirect still lands while the pipe is frozen.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_addr_i);
        end else if (!hold_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem and fills IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0,
    parameter logic [WORD_W-1:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [15:0]       flush_count,
`endif
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_instru,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_instru,
    output logic              id_valid
);
    fetch_state_e      state_q, state_d;
    ifid_t             ifid_q, ifid_d;
    logic [WORD_W-1:0] pc;
    logic              pc_load;
    logic              pc_hold;
    logic              load_en;
    logic              flush_en;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (pc_load),
        .load_addr_i (branch_addr),
        .hold_i      (pc_hold),
        .pc_o        (pc)
    );

    assign imem_addr = word_align(pc);

    // BOOT still honours a redirect but never captures into IF/ID.
    always_comb begin
        state_d  = state_q;
        ifid_d   = ifid_q;
        pc_load  = 1'b0;
        pc_hold  = 1'b1;
        load_en  = 1'b0;
        flush_en = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_load = branch_taken;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_load  = 1'b1;
                    flush_en = 1'b1;
                    ifid_d   = '{pc: '0, instru: INSTR_NOP, valid: 1'b0};
                end else if (!freeze) begin
                    pc_hold = 1'b0;
                    load_en = 1'b1;
                    ifid_d  = '{pc: pc + PC_STEP, instru: imem_instru, valid: 1'b1};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            ifid_q  <= '{pc: '0, instru: INSTR_NOP, valid: 1'b0};
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end
    end

    assign id_pc     = ifid_q.pc;
    assign id_instru = ifid_q.instru;
    assign id_valid  = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (load_en) fetch_count_q <= fetch_count_q + 32'd1;
            if (flush_en) flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model feeds a scoreboard queue per clock.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_instru;
    logic [31:0] id_pc;
    logic [31:0] id_instru;
    logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int errors = 0;
    int checks = 0;

    // Expected {imem_addr, id_pc, id_instru, id_valid} after each clock.
    logic [96:0] sb[$];
    logic [96:0] e;

    logic [31:0] m_pc;
    logic        m_boot;
    logic [31:0] m_idpc;
    logic [31:0] m_ins;
    logic        m_vld;
    logic [31:0] m_fetch;
    logic [15:0] m_flush;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count  (fetch_count),
        .flush_count  (flush_count),
`endif
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_instru  (imem_instru),
        .id_pc        (id_pc),
        .id_instru    (id_instru),
        .id_valid     (id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hE3A0_0014;
            32'h0000_0004: return 32'hE3A0_1A01;
            32'h0000_0090: return 32'hE59F_1004;
            default:       return (a >= 32'hF000_0000) ? 32'h0 : (a ^ 32'hE1A0_0000);
        endcase
    endfunction

    assign imem_instru = mem_word(imem_addr);

    function automatic logic [31:0] al(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_boot = 1'b1; m_idpc = 32'd0; m_ins = 32'd0; m_vld = 1'b0;
        m_fetch = 32'd0; m_flush = 16'd0;
        sb.delete();
    endtask

    // Advance the model by one clock, queue its expectation and clock the DUT.
    task automatic drive_cycle();
        logic [31:0] ins;
        ins = mem_word(al(m_pc));
        if (m_boot) begin
            if (branch_taken) m_pc = al(branch_addr);
            m_boot = 1'b0;
        end else if (branch_taken) begin
            m_pc = al(branch_addr);
            m_idpc = 32'd0; m_ins = 32'd0; m_vld = 1'b0;
            m_flush = m_flush + 16'd1;
        end else if (!freeze) begin
            m_idpc = m_pc + 32'd4; m_ins = ins; m_vld = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fetch = m_fetch + 32'd1;
        end
        sb.push_back({al(m_pc), m_idpc, m_ins, m_vld});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        model_reset();
        #12;
        checks++;
        if ({imem_addr, id_pc, id_instru, id_valid} !== 97'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", {imem_addr, id_pc, id_instru, id_valid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_boot_fetch();
        drive_cycle();
        checks++;
        if (id_valid !== 1'b0 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL boot_cycle got valid=%b addr=%h exp valid=0 addr=0", id_valid, imem_addr);
        end
        void'(sb.pop_front());
        drive_cycle();
        checks++;
        if (id_instru !== 32'hE3A0_0014 || id_pc !== 32'h4 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch got=%h/%h/%b exp=e3a00014/00000004/1", id_instru, id_pc, id_valid);
        end
        void'(sb.pop_front());
        drive_cycle();
        checks++;
        if (id_instru !== 32'hE3A0_1A01 || id_pc !== 32'h8) begin
            errors++;
            $display("FAIL second_fetch got=%h/%h exp=e3a01a01/00000008", id_instru, id_pc);
        end
        e = sb.pop_front();
        checks++;
        if ({imem_addr, id_pc, id_instru, id_valid} !== e) begin
            errors++;
            $display("FAIL boot_sb got=%h exp=%h", {imem_addr, id_pc, id_instru, id_valid}, e);
        end
    endtask

    task automatic test_freeze();
        drive_cycle(); void'(sb.pop_front());
        drive_cycle(); void'(sb.pop_front());
        freeze = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle();
            e = sb.pop_front();
            checks++;
            if (imem_addr !== 32'h10 || id_pc !== 32'h10 || id_instru !== mem_word(32'hC) || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL freeze_hold%0d got addr=%h pc=%h ins=%h v=%b exp addr=10 pc=10", i, imem_addr, id_pc, id_instru, id_valid);
            end
        end
        freeze = 1'b0;
        drive_cycle();
        e = sb.pop_front();
        checks++;
        if (id_pc !== 32'h14 || {imem_addr, id_pc, id_instru, id_valid} !== e) begin
            errors++;
            $display("FAIL freeze_release got=%h exp=%h", {imem_addr, id_pc, id_instru, id_valid}, e);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_addr = 32'h90;
        drive_cycle(); void'(sb.pop_front());
        checks++;
        if (imem_addr !== 32'h90 || id_valid !== 1'b0 || id_instru !== 32'h0 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL branch_flush got addr=%h v=%b ins=%h pc=%h exp addr=90 flush", imem_addr, id_valid, id_instru, id_pc);
        end
        branch_taken = 1'b0;
        drive_cycle(); void'(sb.pop_front());
        checks++;
        if (id_instru !== 32'hE59F_1004 || id_pc !== 32'h94 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_target got=%h/%h/%b exp=e59f1004/00000094/1", id_instru, id_pc, id_valid);
        end
    endtask

    task automatic test_freeze_branch();
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h3E;
        drive_cycle(); void'(sb.pop_front());
        checks++;
        if (imem_addr !== 32'h3C || id_valid !== 1'b0 || id_instru !== 32'h0) begin
            errors++;
            $display("FAIL freeze_branch got addr=%h v=%b ins=%h exp addr=3c v=0 ins=0", imem_addr, id_valid, id_instru);
        end
        freeze = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        drive_cycle(); void'(sb.pop_front());
        branch_taken = 1'b0;
        drive_cycle(); void'(sb.pop_front());
        checks++;
        if (imem_addr !== 32'h0 || id_pc !== 32'h0 || id_valid !== 1'b1 || id_instru !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap got addr=%h pc=%h v=%b ins=%h exp 0/0/1/0", imem_addr, id_pc, id_valid, id_instru);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            freeze       = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            branch_addr  = $urandom;
            drive_cycle();
            e = sb.pop_front();
            checks++;
            if ({imem_addr, id_pc, id_instru, id_valid} !== e) begin
                errors++;
                $display("FAIL random_sb[%0d] got=%h exp=%h", i, {imem_addr, id_pc, id_instru, id_valid}, e);
            end
        end
        freeze = 1'b0; branch_taken = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== m_fetch || flush_count !== m_flush) begin
            errors++;
            $display("FAIL perf_counts got=%0d/%0d exp=%0d/%0d", fetch_count, flush_count, m_fetch, m_flush);
        end
`endif
    endtask

    task automatic test_async_reset();
        drive_cycle(); void'(sb.pop_front());
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_addr, id_pc, id_instru, id_valid} !== 97'd0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {imem_addr, id_pc, id_instru, id_valid});
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 32'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0", fetch_count, flush_count);
        end
`endif
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_cycle();
        e = sb.pop_front();
        checks++;
        if (id_valid !== 1'b0 || {imem_addr, id_pc, id_instru, id_valid} !== e) begin
            errors++;
            $display("FAIL reboot_boot got=%h exp=%h", {imem_addr, id_pc, id_instru, id_valid}, e);
        end
        drive_cycle();
        e = sb.pop_front();
        checks++;
        if (id_instru !== 32'hE3A0_0014 || {imem_addr, id_pc, id_instru, id_valid} !== e) begin
            errors++;
            $display("FAIL reboot_fetch got=%h exp=%h", {imem_addr, id_pc, id_instru, id_valid}, e);
        end
    endtask

    initial begin
        test_reset();
        test_boot_fetch();
        test_freeze();
        test_branch();
        test_freeze_branch();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
